// File: rtl/vga_sync_counter.sv
// VGA raster timing generator: horizontal/vertical pixel counters, registered
// sync outputs and line/frame start strobes, with timing shadowed per frame.
module vga_sync_counter #(
  parameter int REZ_MAX_WIDTH    = 11,
  parameter int SYNC_MAX_WIDTH   = 8,
  // Shadow values held in reset (640x480@60 unless overridden).
  parameter int RST_H_TOTAL      = 800,
  parameter int RST_H_SYNC_WIDTH = 96,
  parameter int RST_V_TOTAL      = 525,
  parameter int RST_V_SYNC_WIDTH = 2,
  parameter bit RST_H_POL        = 1'b0,
  parameter bit RST_V_POL        = 1'b0
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      En,
  input  logic [REZ_MAX_WIDTH-1:0]  H_total,
  input  logic [SYNC_MAX_WIDTH-1:0] H_sync_width,
  input  logic [REZ_MAX_WIDTH-1:0]  V_total,
  input  logic [SYNC_MAX_WIDTH-1:0] V_sync_width,
  input  logic                      H_pol,
  input  logic                      V_pol,
  output logic [REZ_MAX_WIDTH-1:0]  Count_h,
  output logic [REZ_MAX_WIDTH-1:0]  Count_v,
  output logic                      Hsync,
  output logic                      Vsync,
  output logic                      Line_start,
  output logic                      Frame_start
);

  localparam int W  = REZ_MAX_WIDTH;
  localparam int S  = SYNC_MAX_WIDTH;
  localparam int CW = (W > S) ? W : S;

  localparam logic [W-1:0] RST_H_TOTAL_V = W'(RST_H_TOTAL);
  localparam logic [S-1:0] RST_H_SW_V    = S'(RST_H_SYNC_WIDTH);
  localparam logic [W-1:0] RST_V_TOTAL_V = W'(RST_V_TOTAL);
  localparam logic [S-1:0] RST_V_SW_V    = S'(RST_V_SYNC_WIDTH);

  // Shadow timing registers
  logic [W-1:0] h_total_q, h_total_d;
  logic [S-1:0] h_sync_width_q, h_sync_width_d;
  logic [W-1:0] v_total_q, v_total_d;
  logic [S-1:0] v_sync_width_q, v_sync_width_d;
  logic         h_pol_q, h_pol_d;
  logic         v_pol_q, v_pol_d;

  // Counters and registered outputs
  logic [W-1:0] count_h_q, count_h_d;
  logic [W-1:0] count_v_q, count_v_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         line_start_q, line_start_d;
  logic         frame_start_q, frame_start_d;

  logic h_last;
  logic v_last;
  logic frame_wrap;
  logic h_active;
  logic v_active;

  // A total below 2 pins the counter at 0 and makes every advance a wrap;
  // the >= test also recovers a counter that sits beyond its limit.
  assign h_last = (h_total_q < W'(2)) || (count_h_q >= h_total_q - W'(1));
  assign v_last = (v_total_q < W'(2)) || (count_v_q >= v_total_q - W'(1));
  assign frame_wrap = h_last && v_last;

  assign h_active = CW'(count_h_q) < CW'(h_sync_width_q);
  assign v_active = CW'(count_v_q) < CW'(v_sync_width_q);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    h_total_d      = h_total_q;
    h_sync_width_d = h_sync_width_q;
    v_total_d      = v_total_q;
    v_sync_width_d = v_sync_width_q;
    h_pol_d        = h_pol_q;
    v_pol_d        = v_pol_q;
    count_h_d      = count_h_q;
    count_v_d      = count_v_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;

    if (En) begin
      count_h_d = h_last ? '0 : count_h_q + W'(1);
      if (h_last) begin
        count_v_d = v_last ? '0 : count_v_q + W'(1);
      end

      // Sync decodes the pre-edge count with the current shadow set, so it
      // lags the counters by one clock like the downstream active flag.
      hsync_d = h_active ? h_pol_q : ~h_pol_q;
      vsync_d = v_active ? v_pol_q : ~v_pol_q;

      line_start_d  = h_last;
      frame_start_d = frame_wrap;

      // New timing is only adopted at the frame boundary, so a frame never
      // mixes two timing sets.
      if (frame_wrap) begin
        h_total_d      = H_total;
        h_sync_width_d = H_sync_width;
        v_total_d      = V_total;
        v_sync_width_d = V_sync_width;
        h_pol_d        = H_pol;
        v_pol_d        = V_pol;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      h_total_q      <= RST_H_TOTAL_V;
      h_sync_width_q <= RST_H_SW_V;
      v_total_q      <= RST_V_TOTAL_V;
      v_sync_width_q <= RST_V_SW_V;
      h_pol_q        <= RST_H_POL;
      v_pol_q        <= RST_V_POL;
      count_h_q      <= '0;
      count_v_q      <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      h_total_q      <= h_total_d;
      h_sync_width_q <= h_sync_width_d;
      v_total_q      <= v_total_d;
      v_sync_width_q <= v_sync_width_d;
      h_pol_q        <= h_pol_d;
      v_pol_q        <= v_pol_d;
      count_h_q      <= count_h_d;
      count_v_q      <= count_v_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign Count_h     = count_h_q;
  assign Count_v     = count_v_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Line_start  = line_start_q;
  assign Frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_counter.sv
// Directed bench for vga_sync_counter. The reset V_total is shortened to 4 lines
// so whole frames fit in a short run; horizontal timing keeps its 800/96 default.
module tb_vga_sync_counter;

  localparam int W = 11;
  localparam int S = 8;
  localparam int VT = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic [W-1:0] H_total;
  logic [S-1:0] H_sync_width;
  logic [W-1:0] V_total;
  logic [S-1:0] V_sync_width;
  logic         H_pol;
  logic         V_pol;
  logic [W-1:0] Count_h;
  logic [W-1:0] Count_v;
  logic         Hsync;
  logic         Vsync;
  logic         Line_start;
  logic         Frame_start;

  int checks = 0;
  int failures = 0;

  vga_sync_counter #(
    .REZ_MAX_WIDTH (W),
    .SYNC_MAX_WIDTH(S),
    .RST_V_TOTAL   (VT)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .En          (En),
    .H_total     (H_total),
    .H_sync_width(H_sync_width),
    .V_total     (V_total),
    .V_sync_width(V_sync_width),
    .H_pol       (H_pol),
    .V_pol       (V_pol),
    .Count_h     (Count_h),
    .Count_v     (Count_v),
    .Hsync       (Hsync),
    .Vsync       (Vsync),
    .Line_start  (Line_start),
    .Frame_start (Frame_start)
  );

  always #5 Clk = ~Clk;

  // n clock edges with En=1; returns at the following falling edge.
  task automatic run(input int n);
    En = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset;
    Rst = 1'b0; En = 1'b0;
    H_total = 11'd800; H_sync_width = 8'd96; V_total = 11'(VT); V_sync_width = 8'd2;
    H_pol = 1'b0; V_pol = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (Count_h !== 11'd0) begin failures++; $display("FAIL reset count_h got=%0d exp=0", Count_h); end
    checks++; if (Count_v !== 11'd0) begin failures++; $display("FAIL reset count_v got=%0d exp=0", Count_v); end
    checks++; if (Hsync !== 1'b1) begin failures++; $display("FAIL reset hsync got=%b exp=1", Hsync); end
    checks++; if (Vsync !== 1'b1) begin failures++; $display("FAIL reset vsync got=%b exp=1", Vsync); end
    checks++; if (Line_start !== 1'b0) begin failures++; $display("FAIL reset line_start got=%b exp=0", Line_start); end
    checks++; if (Frame_start !== 1'b0) begin failures++; $display("FAIL reset frame_start got=%b exp=0", Frame_start); end
    Rst = 1'b1;
    @(negedge Clk);
    checks++; if (Count_h !== 11'd0) begin failures++; $display("FAIL release_no_en count_h got=%0d exp=0", Count_h); end
  endtask

  task automatic test_first_edge;
    run(1);
    checks++; if (Count_h !== 11'd1) begin failures++; $display("FAIL first_edge count_h got=%0d exp=1", Count_h); end
    checks++; if (Count_v !== 11'd0) begin failures++; $display("FAIL first_edge count_v got=%0d exp=0", Count_v); end
    checks++; if (Hsync !== 1'b0) begin failures++; $display("FAIL first_edge hsync got=%b exp=0", Hsync); end
    checks++; if (Vsync !== 1'b0) begin failures++; $display("FAIL first_edge vsync got=%b exp=0", Vsync); end
    checks++; if (Line_start !== 1'b0) begin failures++; $display("FAIL first_edge line_start got=%b exp=0", Line_start); end
  endtask

  // Edges 2..1601 after release: 800-pixel lines, Hsync low while the previous
  // count was 0..95.
  task automatic test_line_sequence;
    logic [W-1:0] eh, ev;
    logic         ehs, els;
    for (int k = 2; k <= 1601; k++) begin
      run(1);
      eh  = W'(k % 800);
      ev  = W'(k / 800);
      ehs = (((k - 1) % 800) < 96) ? 1'b0 : 1'b1;
      els = (k % 800 == 0);
      checks++; if (Count_h !== eh) begin failures++; $display("FAIL line k=%0d count_h got=%0d exp=%0d", k, Count_h, eh); end
      checks++; if (Count_v !== ev) begin failures++; $display("FAIL line k=%0d count_v got=%0d exp=%0d", k, Count_v, ev); end
      checks++; if (Hsync !== ehs) begin failures++; $display("FAIL line k=%0d hsync got=%b exp=%b", k, Hsync, ehs); end
      checks++; if (Line_start !== els) begin failures++; $display("FAIL line k=%0d line_start got=%b exp=%b", k, Line_start, els); end
    end
  endtask

  // Edges 1602..3201: frame wraps at edge 3200, Vsync low on lines 0..1.
  task automatic test_frame;
    logic [W-1:0] eh, ev;
    logic         evs, efs;
    for (int k = 1602; k <= 3201; k++) begin
      run(1);
      eh  = W'(k % 800);
      ev  = W'((k / 800) % VT);
      evs = ((((k - 1) / 800) % VT) < 2) ? 1'b0 : 1'b1;
      efs = (k % (800 * VT) == 0);
      checks++; if (Count_h !== eh) begin failures++; $display("FAIL frame k=%0d count_h got=%0d exp=%0d", k, Count_h, eh); end
      checks++; if (Count_v !== ev) begin failures++; $display("FAIL frame k=%0d count_v got=%0d exp=%0d", k, Count_v, ev); end
      checks++; if (Vsync !== evs) begin failures++; $display("FAIL frame k=%0d vsync got=%b exp=%b", k, Vsync, evs); end
      checks++; if (Frame_start !== efs) begin failures++; $display("FAIL frame k=%0d frame_start got=%b exp=%b", k, Frame_start, efs); end
      if (efs) begin
        checks++; if (Line_start !== 1'b1) begin failures++; $display("FAIL frame k=%0d line_start got=%b exp=1", k, Line_start); end
      end
    end
  endtask

  task automatic test_en_toggle;
    run(798);
    checks++; if (Count_h !== 11'd799) begin failures++; $display("FAIL en_toggle pre count_h got=%0d exp=799", Count_h); end
    En = 1'b0; @(negedge Clk);
    checks++; if (Count_h !== 11'd799) begin failures++; $display("FAIL en_toggle hold0 count_h got=%0d exp=799", Count_h); end
    checks++; if (Line_start !== 1'b0) begin failures++; $display("FAIL en_toggle hold0 line_start got=%b exp=0", Line_start); end
    checks++; if (Hsync !== 1'b1) begin failures++; $display("FAIL en_toggle hold0 hsync got=%b exp=1", Hsync); end
    run(1);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1) begin failures++; $display("FAIL en_toggle step1 count got=(%0d,%0d) exp=(0,1)", Count_h, Count_v); end
    checks++; if (Line_start !== 1'b1) begin failures++; $display("FAIL en_toggle step1 line_start got=%b exp=1", Line_start); end
    En = 1'b0; @(negedge Clk);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1) begin failures++; $display("FAIL en_toggle hold1 count got=(%0d,%0d) exp=(0,1)", Count_h, Count_v); end
    checks++; if (Line_start !== 1'b0) begin failures++; $display("FAIL en_toggle hold1 line_start got=%b exp=0", Line_start); end
    run(1);
    checks++; if (Count_h !== 11'd1) begin failures++; $display("FAIL en_toggle step2 count_h got=%0d exp=1", Count_h); end
    checks++; if (Hsync !== 1'b0) begin failures++; $display("FAIL en_toggle step2 hsync got=%b exp=0", Hsync); end
    En = 1'b0; @(negedge Clk);
    checks++; if (Count_h !== 11'd1 || Hsync !== 1'b0) begin failures++; $display("FAIL en_toggle hold2 count_h/hsync got=%0d/%b exp=1/0", Count_h, Hsync); end
  endtask

  // At (1,1): request 1056-pixel lines and high-polarity Hsync mid-frame.
  task automatic test_mid_frame_change;
    H_total = 11'd1056; H_pol = 1'b1;
    run(799);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd2) begin failures++; $display("FAIL midframe old_len count got=(%0d,%0d) exp=(0,2)", Count_h, Count_v); end
    run(1);
    checks++; if (Hsync !== 1'b0) begin failures++; $display("FAIL midframe old_pol hsync got=%b exp=0", Hsync); end
    run(1598);
    checks++; if (Count_h !== 11'd799 || Count_v !== 11'd3) begin failures++; $display("FAIL midframe last count got=(%0d,%0d) exp=(799,3)", Count_h, Count_v); end
    run(1);
    checks++; if (Frame_start !== 1'b1 || Count_h !== 11'd0 || Count_v !== 11'd0) begin failures++; $display("FAIL midframe wrap fs/count got=%b/(%0d,%0d) exp=1/(0,0)", Frame_start, Count_h, Count_v); end
    checks++; if (Hsync !== 1'b1) begin failures++; $display("FAIL midframe wrap hsync got=%b exp=1", Hsync); end
    run(1);
    checks++; if (Hsync !== 1'b1) begin failures++; $display("FAIL midframe new_pol_active hsync got=%b exp=1", Hsync); end
    run(96);
    checks++; if (Count_h !== 11'd97 || Hsync !== 1'b0) begin failures++; $display("FAIL midframe new_pol_inactive count_h/hsync got=%0d/%b exp=97/0", Count_h, Hsync); end
    run(702);
    checks++; if (Count_h !== 11'd799 || Count_v !== 11'd0) begin failures++; $display("FAIL midframe new_len count got=(%0d,%0d) exp=(799,0)", Count_h, Count_v); end
    run(256);
    checks++; if (Count_h !== 11'd1055 || Hsync !== 1'b0) begin failures++; $display("FAIL midframe end_line count_h/hsync got=%0d/%b exp=1055/0", Count_h, Hsync); end
    run(1);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1 || Line_start !== 1'b1) begin failures++; $display("FAIL midframe new_wrap count/ls got=(%0d,%0d)/%b exp=(0,1)/1", Count_h, Count_v, Line_start); end
  endtask

  // Request a 100-pixel line while Count_h=500 on the last line; also a zero
  // Hsync width and a Vsync width beyond V_total.
  task automatic test_shrink_and_widths;
    run(2612);
    checks++; if (Count_h !== 11'd500 || Count_v !== 11'd3) begin failures++; $display("FAIL shrink pre count got=(%0d,%0d) exp=(500,3)", Count_h, Count_v); end
    H_total = 11'd100; H_sync_width = 8'd0; V_sync_width = 8'd255;
    run(555);
    checks++; if (Count_h !== 11'd1055 || Line_start !== 1'b0) begin failures++; $display("FAIL shrink keep count_h/ls got=%0d/%b exp=1055/0", Count_h, Line_start); end
    run(1);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd0 || Frame_start !== 1'b1) begin failures++; $display("FAIL shrink wrap count/fs got=(%0d,%0d)/%b exp=(0,0)/1", Count_h, Count_v, Frame_start); end
    run(99);
    checks++; if (Count_h !== 11'd99) begin failures++; $display("FAIL shrink short count_h got=%0d exp=99", Count_h); end
    checks++; if (Hsync !== 1'b0) begin failures++; $display("FAIL width0 hsync got=%b exp=0", Hsync); end
    checks++; if (Vsync !== 1'b0) begin failures++; $display("FAIL widthmax vsync_l0 got=%b exp=0", Vsync); end
    run(1);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1 || Line_start !== 1'b1) begin failures++; $display("FAIL shrink line100 count/ls got=(%0d,%0d)/%b exp=(0,1)/1", Count_h, Count_v, Line_start); end
    run(300);
    checks++; if (Frame_start !== 1'b1 || Count_v !== 11'd0) begin failures++; $display("FAIL shrink frame400 fs/count_v got=%b/%0d exp=1/0", Frame_start, Count_v); end
    checks++; if (Vsync !== 1'b0 || Hsync !== 1'b0) begin failures++; $display("FAIL widthmax vsync/hsync got=%b/%b exp=0/0", Vsync, Hsync); end
  endtask

  // Horizontal total of 1: every advance wraps the line.
  task automatic test_short_total;
    H_total = 11'd1; H_sync_width = 8'd5; V_total = 11'd3;
    run(400);
    checks++; if (Frame_start !== 1'b1) begin failures++; $display("FAIL short reload frame_start got=%b exp=1", Frame_start); end
    run(1);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1) begin failures++; $display("FAIL short e1 count got=(%0d,%0d) exp=(0,1)", Count_h, Count_v); end
    checks++; if (Line_start !== 1'b1 || Frame_start !== 1'b0) begin failures++; $display("FAIL short e1 ls/fs got=%b/%b exp=1/0", Line_start, Frame_start); end
    checks++; if (Hsync !== 1'b1) begin failures++; $display("FAIL short e1 hsync got=%b exp=1", Hsync); end
    run(1);
    checks++; if (Count_v !== 11'd2 || Line_start !== 1'b1) begin failures++; $display("FAIL short e2 count_v/ls got=%0d/%b exp=2/1", Count_v, Line_start); end
    run(1);
    checks++; if (Count_v !== 11'd0 || Frame_start !== 1'b1 || Line_start !== 1'b1) begin failures++; $display("FAIL short e3 count_v/fs/ls got=%0d/%b/%b exp=0/1/1", Count_v, Frame_start, Line_start); end
    En = 1'b0; @(negedge Clk);
    checks++; if (Line_start !== 1'b0 || Frame_start !== 1'b0) begin failures++; $display("FAIL short en0 ls/fs got=%b/%b exp=0/0", Line_start, Frame_start); end
  endtask

  task automatic test_async_reset;
    H_total = 11'd400; H_sync_width = 8'd96; V_total = 11'd300; V_sync_width = 8'd2;
    H_pol = 1'b0; V_pol = 1'b0;
    run(3);
    checks++; if (Frame_start !== 1'b1) begin failures++; $display("FAIL areset reload frame_start got=%b exp=1", Frame_start); end
    run(1100);
    checks++; if (Count_h !== 11'd300 || Count_v !== 11'd2) begin failures++; $display("FAIL areset pre count got=(%0d,%0d) exp=(300,2)", Count_h, Count_v); end
    #2 Rst = 1'b0;
    #1;
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd0) begin failures++; $display("FAIL areset async count got=(%0d,%0d) exp=(0,0)", Count_h, Count_v); end
    checks++; if (Hsync !== 1'b1 || Vsync !== 1'b1) begin failures++; $display("FAIL areset async sync got=%b/%b exp=1/1", Hsync, Vsync); end
    @(negedge Clk);
    Rst = 1'b1; En = 1'b0;
    @(negedge Clk);
    run(1);
    checks++; if (Count_h !== 11'd1 || Hsync !== 1'b0) begin failures++; $display("FAIL areset resume count_h/hsync got=%0d/%b exp=1/0", Count_h, Hsync); end
    run(799);
    checks++; if (Count_h !== 11'd0 || Count_v !== 11'd1 || Line_start !== 1'b1) begin failures++; $display("FAIL areset default_len count/ls got=(%0d,%0d)/%b exp=(0,1)/1", Count_h, Count_v, Line_start); end
  endtask

  initial begin
    test_reset;
    test_first_edge;
    test_line_sequence;
    test_frame;
    test_en_toggle;
    test_mid_frame_change;
    test_shrink_and_widths;
    test_short_total;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
